// File: rtl/memory_fetch_unit_pkg.sv
// Shared definitions for the memory fetch unit: FSM state encoding and fetch length codes.
package memory_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_LO  = 3'd1,
    S_REQ_HI  = 3'd2,
    S_CAPT_LO = 3'd3,
    S_CAPT_HI = 3'd4,
    S_DONE    = 3'd5
  } fetch_state_t;

  localparam logic LEN_BYTE = 1'b0;
  localparam logic LEN_WORD = 1'b1;

endpackage

// File: rtl/memory_fetch_unit.sv
// One- or two-byte little-endian memory fetch with optional per-byte address-increment strobes.
module memory_fetch_unit
  import memory_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        len,
  input  logic        inc_en,
  input  logic [15:0] addr_in,
  input  logic [7:0]  mem_data,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        addr_inc,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy
);

  fetch_state_t state;
  logic [15:0]  base_q;
  logic         len_q;
  logic         inc_en_q;
  logic [15:0]  addr_hi;

  // Second byte address wraps naturally at 16 bits.
  assign addr_hi = base_q + 16'd1;

  // Outputs are registered together with the state they belong to, so
  // mem_re/mem_addr/addr_inc/done/busy always match the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= 16'h0000;
      len_q    <= LEN_BYTE;
      inc_en_q <= 1'b0;
      data_out <= 16'h0000;
      mem_addr <= 16'h0000;
      mem_re   <= 1'b0;
      addr_inc <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_re   <= 1'b0;
      mem_addr <= 16'h0000;
      addr_inc <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= addr_in;
            len_q    <= len;
            inc_en_q <= inc_en;
            state    <= S_REQ_LO;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= addr_in;
            addr_inc <= inc_en;
          end
        end
        S_REQ_LO: begin
          if (len_q == LEN_WORD) begin
            state    <= S_REQ_HI;
            mem_re   <= 1'b1;
            mem_addr <= addr_hi;
            addr_inc <= inc_en_q;
          end else begin
            state <= S_CAPT_LO;
          end
        end
        S_REQ_HI: begin
          data_out[7:0] <= mem_data;
          state         <= S_CAPT_HI;
        end
        S_CAPT_HI: begin
          data_out[15:8] <= mem_data;
          state          <= S_DONE;
          done           <= 1'b1;
        end
        S_CAPT_LO: begin
          data_out <= {8'h00, mem_data};
          state    <= S_DONE;
          done     <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_fetch_unit.sv
// Directed bench for memory_fetch_unit with a one-cycle-latency memory model.
module tb_memory_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, len, inc_en;
  logic [15:0] addr_in;
  logic [7:0]  mem_data;
  logic [15:0] mem_addr;
  logic        mem_re, addr_inc, done, busy;
  logic [15:0] data_out;

  logic [7:0]  mem [65536];
  int          tests = 0;
  int          fails = 0;

  memory_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .inc_en(inc_en),
    .addr_in(addr_in), .mem_data(mem_data), .mem_addr(mem_addr),
    .mem_re(mem_re), .addr_inc(addr_inc), .data_out(data_out),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_data <= mem[mem_addr];
    else        mem_data <= 8'hEE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic l, input logic ie, input logic [15:0] a);
    start = 1'b1; len = l; inc_en = ie; addr_in = a;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 1'b1; inc_en = 1'b1; addr_in = 16'h1234;
    step(); step();
    rst = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL reset_mem_re got %b exp 0", mem_re); end
    tests++; if (addr_inc !== 1'b0) begin fails++; $display("FAIL reset_addr_inc got %b exp 0", addr_inc); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
    tests++; if (data_out !== 16'h0000) begin fails++; $display("FAIL reset_data_out got %h exp 0000", data_out); end
  endtask

  task automatic test_word_fetch();
    int incs = 0;
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    issue(1'b1, 1'b1, 16'h0040);
    addr_in = 16'h7777;
    // cycle 1
    incs += int'(addr_inc);
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h0040) begin fails++; $display("FAIL word_c1_addr got re=%b addr=%h exp re=1 addr=0040", mem_re, mem_addr); end
    step(); // cycle 2
    incs += int'(addr_inc);
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h0041) begin fails++; $display("FAIL word_c2_addr got re=%b addr=%h exp re=1 addr=0041", mem_re, mem_addr); end
    step(); // cycle 3
    incs += int'(addr_inc);
    tests++; if (mem_re !== 1'b0 || mem_addr !== 16'h0000 || done !== 1'b0) begin fails++; $display("FAIL word_c3_idle_bus got re=%b addr=%h done=%b exp 0/0000/0", mem_re, mem_addr, done); end
    step(); // cycle 4
    incs += int'(addr_inc);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL word_done_c4 got %b exp 1", done); end
    tests++; if (data_out !== 16'h1234) begin fails++; $display("FAIL word_data got %h exp 1234", data_out); end
    tests++; if (incs != 2) begin fails++; $display("FAIL word_inc_pulses got %0d exp 2", incs); end
    step(); // cycle 5
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL word_c5_idle got done=%b busy=%b exp 0/0", done, busy); end
    tests++; if (data_out !== 16'h1234) begin fails++; $display("FAIL word_data_hold got %h exp 1234", data_out); end
  endtask

  task automatic test_byte_fetch();
    int incs = 0;
    int res = 0;
    mem[16'h0100] = 8'hAB;
    issue(1'b0, 1'b0, 16'h0100);
    for (int c = 1; c <= 4; c++) begin
      incs += int'(addr_inc);
      res  += int'(mem_re);
      if (c == 1) begin
        tests++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL byte_addr got %h exp 0100", mem_addr); end
      end
      if (c == 2) begin
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL byte_early_done got %b exp 0", done); end
      end
      if (c == 3) begin
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL byte_done_c3 got %b exp 1", done); end
        tests++; if (data_out !== 16'h00AB) begin fails++; $display("FAIL byte_data got %h exp 00ab", data_out); end
      end
      if (c == 4) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL byte_busy_c4 got %b exp 0", busy); end
      end
      step();
    end
    tests++; if (res != 1) begin fails++; $display("FAIL byte_mem_re_count got %0d exp 1", res); end
    tests++; if (incs != 0) begin fails++; $display("FAIL byte_inc_pulses got %0d exp 0", incs); end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    issue(1'b1, 1'b0, 16'hFFFF);
    tests++; if (mem_addr !== 16'hFFFF || addr_inc !== 1'b0) begin fails++; $display("FAIL wrap_c1 got addr=%h inc=%b exp ffff/0", mem_addr, addr_inc); end
    step();
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_addr got re=%b addr=%h exp 1/0000", mem_re, mem_addr); end
    step(); step();
    tests++; if (done !== 1'b1 || data_out !== 16'h2211) begin fails++; $display("FAIL wrap_data got done=%b data=%h exp 1/2211", done, data_out); end
    step();
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    mem[16'h0200] = 8'h99; mem[16'h0300] = 8'h88;
    issue(1'b1, 1'b1, 16'h0040);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy_c1 got %b exp 1", busy); end
    start = 1'b1; len = 1'b0; inc_en = 1'b0; addr_in = 16'h0200;
    step(); // cycle 2
    tests++; if (mem_addr !== 16'h0041 || addr_inc !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL ign_c2 got addr=%h inc=%b busy=%b exp 0041/1/1", mem_addr, addr_inc, busy); end
    addr_in = 16'h0300;
    step(); // cycle 3
    start = 1'b0;
    tests++; if (busy !== 1'b1 || mem_re !== 1'b0) begin fails++; $display("FAIL ign_c3 got busy=%b re=%b exp 1/0", busy, mem_re); end
    step(); // cycle 4
    tests++; if (busy !== 1'b1 || done !== 1'b1 || data_out !== 16'h1234) begin fails++; $display("FAIL ign_c4 got busy=%b done=%b data=%h exp 1/1/1234", busy, done, data_out); end
    for (int c = 5; c <= 9; c++) begin
      step();
      dones += int'(done) + int'(mem_re);
    end
    tests++; if (dones != 0 || busy !== 1'b0) begin fails++; $display("FAIL ign_no_queue got extra=%0d busy=%b exp 0/0", dones, busy); end
  endtask

  task automatic test_abort();
    int act = 0;
    mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'hC3;
    issue(1'b1, 1'b1, 16'h0040);
    step(); // cycle 2: REQ_HI
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if ({mem_re, addr_inc, done, busy} !== 4'b0000 || mem_addr !== 16'h0000 || data_out !== 16'h0000) begin fails++; $display("FAIL abort_outputs got re=%b inc=%b done=%b busy=%b addr=%h data=%h exp all 0", mem_re, addr_inc, done, busy, mem_addr, data_out); end
    for (int c = 0; c < 4; c++) begin
      step();
      act += int'(done) + int'(mem_re) + int'(addr_inc);
    end
    tests++; if (act != 0) begin fails++; $display("FAIL abort_quiet got activity=%0d exp 0", act); end
    issue(1'b1, 1'b0, 16'h0010);
    tests++; if (mem_addr !== 16'h0010) begin fails++; $display("FAIL abort_restart_addr got %h exp 0010", mem_addr); end
    step(); step(); step();
    tests++; if (done !== 1'b1 || data_out !== 16'hC35A) begin fails++; $display("FAIL abort_restart got done=%b data=%h exp 1/c35a", done, data_out); end
    step();
  endtask

  task automatic test_back_to_back();
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    issue(1'b1, 1'b1, 16'h0040);
    step(); step(); step(); // cycle 4
    tests++; if (done !== 1'b1 || data_out !== 16'h1234) begin fails++; $display("FAIL b2b_first got done=%b data=%h exp 1/1234", done, data_out); end
    step(); // cycle 5
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_c5_busy got %b exp 0", busy); end
    issue(1'b1, 1'b0, 16'hFFFF); // start sampled at cycle 5
    tests++; if (busy !== 1'b1 || mem_addr !== 16'hFFFF) begin fails++; $display("FAIL b2b_accept got busy=%b addr=%h exp 1/ffff", busy, mem_addr); end
    step(); step(); // cycle 8
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_c8_done got %b exp 0", done); end
    step(); // cycle 9
    tests++; if (done !== 1'b1 || data_out !== 16'h2211) begin fails++; $display("FAIL b2b_second got done=%b data=%h exp 1/2211", done, data_out); end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 1'b0; inc_en = 1'b0; addr_in = 16'h0000;
    test_reset();
    test_word_fetch();
    test_byte_fetch();
    test_wrap();
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
